// File: rtl/cmp_window_stats.sv
// Windowed statistics over one-hot comparator flags: counts gt/lt/eq over WINDOW accepts, reports counts and majority verdict.
// Optional one-hot legality check enabled by defining CMP_STATS_ONEHOT_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for start; counts hold last window
// ACC    | accepting samples until WINDOW accepts seen
// REPORT | result presented until out_ready handshake
module cmp_window_stats #(
    parameter int WINDOW = 8,
    localparam int CW = $clog2(WINDOW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic          in_gt,
    input  logic          in_lt,
    input  logic          in_eq,
    output logic          in_ready,
    output logic [CW-1:0] gt_cnt,
    output logic [CW-1:0] lt_cnt,
    output logic [CW-1:0] eq_cnt,
    output logic [1:0]    verdict,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC    = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [CW-1:0] WIN_C = CW'(WINDOW);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] gt_cnt_q, gt_cnt_d;
    logic [CW-1:0] lt_cnt_q, lt_cnt_d;
    logic [CW-1:0] eq_cnt_q, eq_cnt_d;
    logic [CW-1:0] smp_cnt_q, smp_cnt_d;
    logic [1:0]    verdict_q, verdict_d;
    logic          accept;
    logic          last_accept;
    logic          sample_ok;
`ifdef CMP_STATS_ONEHOT_CHECK_EN
    logic          err_q, err_d;
`endif

    // Strictly largest count wins; any shared maximum is a tie.
    function automatic logic [1:0] verdict_of(input logic [CW-1:0] g,
                                              input logic [CW-1:0] l,
                                              input logic [CW-1:0] e);
        if (g > l && g > e)      return 2'b01;
        else if (l > g && l > e) return 2'b10;
        else if (e > g && e > l) return 2'b00;
        else                     return 2'b11;
    endfunction

    assign accept      = in_valid && (state_q == ACC);
    assign last_accept = accept && (smp_cnt_q == WIN_C - ONE_C);

`ifdef CMP_STATS_ONEHOT_CHECK_EN
    assign sample_ok = ({1'b0, in_gt} + {1'b0, in_lt} + {1'b0, in_eq}) == 2'd1;
`else
    assign sample_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gt_cnt_q  <= '0;
            lt_cnt_q  <= '0;
            eq_cnt_q  <= '0;
            smp_cnt_q <= '0;
            verdict_q <= 2'b00;
`ifdef CMP_STATS_ONEHOT_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gt_cnt_q  <= gt_cnt_d;
            lt_cnt_q  <= lt_cnt_d;
            eq_cnt_q  <= eq_cnt_d;
            smp_cnt_q <= smp_cnt_d;
            verdict_q <= verdict_d;
`ifdef CMP_STATS_ONEHOT_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACC;
            ACC:     if (last_accept) state_d = REPORT;
            REPORT:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gt_cnt_d  = gt_cnt_q;
        lt_cnt_d  = lt_cnt_q;
        eq_cnt_d  = eq_cnt_q;
        smp_cnt_d = smp_cnt_q;
        verdict_d = verdict_q;
`ifdef CMP_STATS_ONEHOT_CHECK_EN
        err_d     = err_q;
`endif
        if (state_q == IDLE && start) begin
            gt_cnt_d  = '0;
            lt_cnt_d  = '0;
            eq_cnt_d  = '0;
            smp_cnt_d = '0;
`ifdef CMP_STATS_ONEHOT_CHECK_EN
            err_d     = 1'b0;
`endif
        end else if (accept) begin
            smp_cnt_d = smp_cnt_q + ONE_C;
            if (!sample_ok) begin
`ifdef CMP_STATS_ONEHOT_CHECK_EN
                err_d = 1'b1;
`endif
            end else if (in_gt) begin
                gt_cnt_d = gt_cnt_q + ONE_C;
            end else if (in_lt) begin
                lt_cnt_d = lt_cnt_q + ONE_C;
            end else begin
                eq_cnt_d = eq_cnt_q + ONE_C;
            end
            // Verdict latched from the final counts so it is stable throughout REPORT.
            if (last_accept) verdict_d = verdict_of(gt_cnt_d, lt_cnt_d, eq_cnt_d);
        end
    end

    always_comb begin
        in_ready  = (state_q == ACC);
        out_valid = (state_q == REPORT);
        busy      = (state_q == ACC) || (state_q == REPORT);
    end

    assign gt_cnt  = gt_cnt_q;
    assign lt_cnt  = lt_cnt_q;
    assign eq_cnt  = eq_cnt_q;
    assign verdict = verdict_q;
`ifdef CMP_STATS_ONEHOT_CHECK_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cmp_window_stats.sv
// Directed bench for cmp_window_stats at WINDOW=8; expectations follow CMP_STATS_ONEHOT_CHECK_EN.
module tb_cmp_window_stats;

    localparam int WINDOW = 8;
    localparam int CW = $clog2(WINDOW + 1);

    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_gt, in_lt, in_eq, out_ready;
    logic          in_ready, out_valid, busy, err;
    logic [CW-1:0] gt_cnt, lt_cnt, eq_cnt;
    logic [1:0]    verdict;

    int errors = 0;
    int checks = 0;
    logic [2:0] pat [8];

    cmp_window_stats #(.WINDOW(WINDOW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_gt(in_gt), .in_lt(in_lt), .in_eq(in_eq), .in_ready(in_ready),
        .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .eq_cnt(eq_cnt), .verdict(verdict),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic g, input logic l, input logic e);
        in_valid = 1'b1;
        {in_gt, in_lt, in_eq} = {g, l, e};
        tick();
        in_valid = 1'b0;
        {in_gt, in_lt, in_eq} = 3'b000;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic chk_counts(input string tag, input int g, input int l, input int e);
        chk({tag, "_gt"}, 32'(gt_cnt), g);
        chk({tag, "_lt"}, 32'(lt_cnt), l);
        chk({tag, "_eq"}, 32'(eq_cnt), e);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        {in_gt, in_lt, in_eq} = 3'b000;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_counts("reset", 0, 0, 0);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_in_ready", 32'(in_ready), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_err", 32'(err), 0);
        chk("reset_verdict", 32'(verdict), 0);

        // GT majority: 5 gt, 2 lt, 1 eq back to back
        do_start();
        chk("gt_in_ready", 32'(in_ready), 1);
        chk("gt_busy", 32'(busy), 1);
        for (int i = 0; i < 5; i++) feed(1, 0, 0);
        feed(0, 1, 0);
        feed(0, 1, 0);
        chk("gt_not_yet", 32'(out_valid), 0);
        feed(0, 0, 1);
        chk("gt_out_valid", 32'(out_valid), 1);
        chk("gt_in_ready_low", 32'(in_ready), 0);
        chk_counts("gt", 5, 2, 1);
        chk("gt_verdict", 32'(verdict), 1);
        handshake();
        chk("gt_idle_out_valid", 32'(out_valid), 0);
        chk("gt_idle_busy", 32'(busy), 0);
        chk_counts("gt_hold", 5, 2, 1);

        // Tie with 4 cycles of backpressure
        do_start();
        for (int i = 0; i < 3; i++) feed(1, 0, 0);
        for (int i = 0; i < 3; i++) feed(0, 1, 0);
        feed(0, 0, 1);
        feed(0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            chk("tie_out_valid", 32'(out_valid), 1);
            chk("tie_verdict", 32'(verdict), 3);
            chk_counts("tie", 3, 3, 2);
            chk("tie_busy", 32'(busy), 1);
            tick();
        end
        handshake();
        chk("tie_idle_out_valid", 32'(out_valid), 0);
        chk("tie_idle_in_ready", 32'(in_ready), 0);
        chk("tie_idle_busy", 32'(busy), 0);

        // Gapped input with a start pulse during ACC
        pat[0] = 3'b010; pat[1] = 3'b010; pat[2] = 3'b010; pat[3] = 3'b010;
        pat[4] = 3'b100; pat[5] = 3'b001; pat[6] = 3'b010; pat[7] = 3'b100;
        do_start();
        for (int i = 0; i < 15; i++) begin
            if (i % 2 == 0) begin
                in_valid = 1'b1;
                {in_gt, in_lt, in_eq} = pat[i / 2];
            end else begin
                in_valid = 1'b0;
                {in_gt, in_lt, in_eq} = 3'b100;
            end
            start = (i == 3);
            tick();
            start = 1'b0;
            if (i < 14) begin
                chk("gap_out_valid_low", 32'(out_valid), 0);
                chk("gap_in_ready", 32'(in_ready), 1);
            end
        end
        in_valid = 1'b0;
        {in_gt, in_lt, in_eq} = 3'b000;
        chk("gap_out_valid", 32'(out_valid), 1);
        chk_counts("gap", 2, 5, 1);
        chk("gap_verdict", 32'(verdict), 2);
        handshake();

        // Mid-window reset then a fresh window
        do_start();
        for (int i = 0; i < 4; i++) feed(1, 0, 0);
        chk("mid_gt_partial", 32'(gt_cnt), 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_counts("mid_rst", 0, 0, 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_verdict", 32'(verdict), 0);
        do_start();
        feed(1, 0, 0);
        feed(0, 1, 0);
        feed(0, 1, 0);
        for (int i = 0; i < 5; i++) feed(0, 0, 1);
        chk("mid_out_valid", 32'(out_valid), 1);
        chk_counts("mid_new", 1, 2, 5);
        chk("mid_verdict", 32'(verdict), 0);
        handshake();

        // Illegal flags gt=lt=1
        do_start();
        feed(1, 1, 0);
`ifdef CMP_STATS_ONEHOT_CHECK_EN
        chk("ill_err_set", 32'(err), 1);
`else
        chk("ill_err_set", 32'(err), 0);
`endif
        feed(1, 0, 0);
        feed(1, 0, 0);
        feed(0, 1, 0);
        feed(0, 1, 0);
        for (int i = 0; i < 3; i++) feed(0, 0, 1);
        chk("ill_out_valid", 32'(out_valid), 1);
`ifdef CMP_STATS_ONEHOT_CHECK_EN
        chk_counts("ill", 2, 2, 3);
        chk("ill_sum", 32'(gt_cnt) + 32'(lt_cnt) + 32'(eq_cnt), 7);
        chk("ill_verdict", 32'(verdict), 0);
        chk("ill_err", 32'(err), 1);
`else
        chk_counts("ill", 3, 2, 3);
        chk("ill_sum", 32'(gt_cnt) + 32'(lt_cnt) + 32'(eq_cnt), 8);
        chk("ill_verdict", 32'(verdict), 3);
        chk("ill_err", 32'(err), 0);
`endif
        handshake();
        do_start();
        chk("ill_err_cleared", 32'(err), 0);
        chk_counts("restart_clear", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
